// File: rtl/simple_dp_sched.sv
// Round-robin scheduler sharing one fixed-latency NAND/NOR datapath between NUM_REQ requesters.
// Grants one request per cycle, drives the datapath, and returns each result tagged with its requester ID.
module simple_dp_sched #(
    parameter int  NUM_REQ = 4,
    parameter int  LATENCY = 3,
    parameter int  CNT_W   = 16,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               tau2015_clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_inp1,
    input  logic [NUM_REQ-1:0] req_inp2,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               dp_inp1,
    output logic               dp_inp2,
    output logic               dp_en,
    input  logic               dp_out,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_out,
    output logic               busy,
    output logic [CNT_W-1:0]   issue_cnt
);

    localparam int INF_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              xfer;
    logic [INF_W-1:0]  inflight;
    logic [INF_W-1:0]  inflight_nxt;
    logic [LATENCY-1:0] tag_vld_p;
    logic [ID_W-1:0]   tag_id_p [LATENCY];

    function automatic logic [ID_W-1:0] ptr_wrap(input int idx);
        return ID_W'(idx % NUM_REQ);
    endfunction

    // Grant search starts at rr_ptr and wraps; nothing is granted while draining or in reset.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        if (rst_n && enable && (state != DRAIN)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_found && req_valid[ptr_wrap(int'(rr_ptr) + k)]) begin
                    grant_found = 1'b1;
                    grant_id    = ptr_wrap(int'(rr_ptr) + k);
                end
            end
        end
    end

    assign req_ready    = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
    assign xfer         = grant_found;
    assign inflight_nxt = inflight + INF_W'(xfer) - INF_W'(rsp_valid);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable && (|req_valid))
                    state_nxt = RUN;
            end
            RUN: begin
                if (!enable || !(|req_valid)) begin
                    if (inflight_nxt == '0)
                        state_nxt = IDLE;
                    else if (!enable)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_nxt == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE) || (inflight_nxt != '0);
        end
    end

    // Issue stage: operands and enable presented to the datapath the cycle after the handshake.
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_en     <= 1'b0;
            dp_inp1   <= 1'b0;
            dp_inp2   <= 1'b0;
            rr_ptr    <= '0;
            issue_cnt <= '0;
            inflight  <= '0;
        end else begin
            dp_en    <= xfer;
            dp_inp1  <= xfer & req_inp1[grant_id];
            dp_inp2  <= xfer & req_inp2[grant_id];
            inflight <= inflight_nxt;
            if (xfer) begin
                rr_ptr    <= ptr_wrap(int'(grant_id) + 1);
                issue_cnt <= issue_cnt + 1'b1;
            end
        end
    end

    // Tag pipeline: stage 0 lines up with dp_en, the last stage with the cycle dp_out is valid.
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= xfer;
            for (int i = 1; i < LATENCY; i++)
                tag_vld_p[i] <= tag_vld_p[i-1];
        end
    end

    always_ff @(posedge tau2015_clk) begin
        tag_id_p[0] <= grant_id;
        for (int i = 1; i < LATENCY; i++)
            tag_id_p[i] <= tag_id_p[i-1];
    end

    // Response stage: capture dp_out alongside the matching tag.
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= 1'b0;
        end else begin
            rsp_valid <= tag_vld_p[LATENCY-1];
            rsp_id    <= tag_vld_p[LATENCY-1] ? tag_id_p[LATENCY-1] : '0;
            rsp_out   <= tag_vld_p[LATENCY-1] & dp_out;
        end
    end

endmodule

// File: tb/tb_simple_dp_sched.sv
// Randomized and directed bench for simple_dp_sched against a queue-based model of grants and responses.
module tb_simple_dp_sched;

    localparam int N   = 4;
    localparam int L   = 3;
    localparam int CW  = 16;
    localparam int IDW = 2;

    logic           tau2015_clk;
    logic           rst_n;
    logic           enable;
    logic [N-1:0]   req_valid, req_inp1, req_inp2, req_ready;
    logic           dp_inp1, dp_inp2, dp_en, dp_out;
    logic           rsp_valid, rsp_out, busy;
    logic [IDW-1:0] rsp_id;
    logic [CW-1:0]  issue_cnt;

    simple_dp_sched #(.NUM_REQ(N), .LATENCY(L), .CNT_W(CW)) dut (
        .tau2015_clk(tau2015_clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_inp1(req_inp1), .req_inp2(req_inp2),
        .req_ready(req_ready), .dp_inp1(dp_inp1), .dp_inp2(dp_inp2),
        .dp_en(dp_en), .dp_out(dp_out), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_out(rsp_out), .busy(busy), .issue_cnt(issue_cnt)
    );

    initial begin
        tau2015_clk = 1'b0;
        forever #5 tau2015_clk = ~tau2015_clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model: operations pending by the cycle their response must appear.
    typedef struct { int due; int id; } op_t;
    op_t  pend[$];
    int   m_ptr, m_state, m_cnt;
    bit   dp_hist[16];
    logic e_dp_en, e_i1, e_i2, e_rv, e_ro, e_busy;
    int   e_rid;

    logic [N-1:0] seen_ready;
    logic         last_dp_drv;
    int           grant_log[$];
    int           rsp_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int model_grant(input logic en, input logic [N-1:0] v);
        if (!en || m_state == 2) return -1;
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_ptr = 0; m_state = 0; m_cnt = 0;
        e_dp_en = 0; e_i1 = 0; e_i2 = 0; e_rv = 0; e_ro = 0; e_busy = 0; e_rid = 0;
    endtask

    task automatic model_advance(input int g);
        int infl_nxt;
        logic any_v;
        any_v = |req_valid;
        dp_hist[cyc % 16] = dp_out;
        e_dp_en = (g >= 0);
        e_i1    = (g >= 0) ? req_inp1[g] : 1'b0;
        e_i2    = (g >= 0) ? req_inp2[g] : 1'b0;
        if (g >= 0) begin
            pend.push_back('{due: cyc + L + 1, id: g});
            m_ptr = (g + 1) % N;
            m_cnt = (m_cnt + 1) % 65536;
        end
        e_rv = 0;
        foreach (pend[i]) if (pend[i].due == cyc + 1) begin
            e_rv = 1; e_rid = pend[i].id; e_ro = dp_hist[cyc % 16];
        end
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].due <= cyc) pend.delete(i);
        infl_nxt = pend.size();
        case (m_state)
            0: if (enable && any_v) m_state = 1;
            1: if (!enable || !any_v) begin
                   if (infl_nxt == 0) m_state = 0;
                   else if (!enable) m_state = 2;
               end
            default: if (infl_nxt == 0) m_state = 0;
        endcase
        e_busy = (m_state != 0) || (infl_nxt != 0);
    endtask

    // One clock cycle: drive, check the grant, advance the model, then check registered outputs.
    task automatic step(input logic en, input logic [N-1:0] v, input logic [N-1:0] i1, input logic [N-1:0] i2);
        int g;
        enable = en; req_valid = v; req_inp1 = i1; req_inp2 = i2;
        dp_out = 1'($urandom);
        last_dp_drv = dp_out;
        #1;
        g = model_grant(en, v);
        seen_ready = req_ready;
        chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
        model_advance(g);
        @(posedge tau2015_clk);
        cyc++;
        #1;
        chk("dp_en", dp_en, e_dp_en);
        chk("dp_inp1", dp_inp1, e_i1);
        chk("dp_inp2", dp_inp2, e_i2);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
            chk("rsp_id", rsp_id, e_rid);
            chk("rsp_out", rsp_out, e_ro);
        end
        chk("busy", busy, e_busy);
        chk("issue_cnt", issue_cnt, m_cnt);
        if (rsp_valid) rsp_log.push_back(int'(rsp_id));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_dp"}, {dp_en, dp_inp1, dp_inp2}, 0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_out, rsp_id}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_issue_cnt"}, issue_cnt, 0);
    endtask

    task automatic do_reset();
        enable = 1; req_valid = '1;
        rst_n = 0;
        #1;
        chk_zero("rst_async");
        model_reset();
        @(posedge tau2015_clk);
        cyc++;
        #1;
        enable = 0; req_valid = '0;
        rst_n = 1;
        chk_zero("rst_release");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0);
    endtask

    task automatic chk_seq(input string name, input int q[$], input int e0, input int e1,
                           input int e2, input int e3, input int e4, input int n);
        int e[5];
        e = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", name, i), (q.size() > i) ? q[i] : -1, e[i]);
    endtask

    initial begin
        rst_n = 0; enable = 0; req_valid = '0; req_inp1 = '0; req_inp2 = '0; dp_out = 0;
        model_reset();
        repeat (2) @(posedge tau2015_clk);
        #1;
        chk_zero("reset");
        rst_n = 1;

        // Single request from requester 2 with both operands high.
        idle(2);
        step(1, 4'b0100, 4'b0100, 4'b0100);
        chk("t1_ready", seen_ready, 4'b0100);
        chk("t1_dp", {dp_en, dp_inp1, dp_inp2}, 3'b111);
        idle(3);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_out", rsp_out, last_dp_drv);
        chk("t1_issue_cnt", issue_cnt, 1);
        idle(3);

        // All four held from a fresh pointer.
        do_reset();
        grant_log.delete(); rsp_log.delete();
        for (int i = 0; i < 5; i++) step(1, 4'b1111, 4'($urandom), 4'($urandom));
        idle(6);
        chk_seq("t2_grant", grant_log, 0, 1, 2, 3, 0, 5);
        chk_seq("t2_rsp_id", rsp_log, 0, 1, 2, 3, 0, 5);

        // Pointer at 2 after granting 1; requester 2 masked.
        step(1, 4'b0010, 4'b0010, 4'b0000);
        grant_log.delete();
        for (int i = 0; i < 4; i++) step(1, 4'b1011, 4'($urandom), 4'($urandom));
        chk_seq("t3_grant", grant_log, 3, 0, 1, 3, 0, 4);
        idle(6);

        // Two issues, enable drops, drain ignores enable.
        step(1, 4'b1111, 4'b1111, 4'b0000);
        step(1, 4'b1111, 4'b0000, 4'b1111);
        step(0, 4'b1111, 4'b1111, 4'b1111);
        chk("t4_no_grant_disabled", seen_ready, 0);
        step(1, 4'b1111, 4'b1111, 4'b1111);
        chk("t4_no_grant_drain", seen_ready, 0);
        chk("t4_rsp0", rsp_valid, 1);
        step(0, 4'b0000, 4'b0000, 4'b0000);
        chk("t4_rsp1", rsp_valid, 1);
        chk("t4_busy_hold", busy, 1);
        step(0, 4'b0000, 4'b0000, 4'b0000);
        chk("t4_busy_fall", busy, 0);
        chk("t4_rsp_end", rsp_valid, 0);
        idle(2);

        // Reset while an op is in flight.
        step(1, 4'b0100, 4'b0100, 4'b0100);
        idle(1);
        do_reset();
        idle(1);
        chk("t5_no_rsp", rsp_valid, 0);
        chk("t5_issue_cnt", issue_cnt, 0);
        idle(4);

        // Issue counter wrap.
        do_reset();
        for (int i = 0; i < 65535; i++) step(1, 4'b1111, 4'($urandom), 4'($urandom));
        chk("t6_cnt_max", issue_cnt, 16'hFFFF);
        step(1, 4'b1111, 4'($urandom), 4'($urandom));
        chk("t6_cnt_wrap", issue_cnt, 16'h0000);
        idle(6);

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(($urandom % 5) != 0, 4'($urandom), 4'($urandom), 4'($urandom));
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simple_dp_sched.md
Name: simple_dp_sched

Overview:
- Round-robin scheduler that shares one instance of the NAND/NOR feedback-flop datapath between NUM_REQ requesters.
- Arbitrates one request per cycle and drives the datapath inputs and clock-enable.
- Tracks in-flight operations through a fixed-latency tag pipeline and returns each result tagged with the requester ID.
- Sits between requester logic and the shared datapath cell cluster.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LATENCY, 3, cycles from datapath input drive to valid dp_out (1..8)
ID_W, clog2(NUM_REQ), requester ID width (derived, not overridable)
CNT_W, 16, width of issue counter

Ports:
tau2015_clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits new issues when high
req_valid  input  NUM_REQ  per-requester request
req_inp1  input  NUM_REQ  per-requester operand 1
req_inp2  input  NUM_REQ  per-requester operand 2
req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
dp_inp1  output  1  datapath operand 1 (registered)
dp_inp2  output  1  datapath operand 2 (registered)
dp_en  output  1  datapath enable (registered), high only on issued cycles
dp_out  input  1  datapath result
rsp_valid  output  1  result valid, one-cycle pulse, no backpressure
rsp_id  output  ID_W  requester ID of result
rsp_out  output  1  result bit
busy  output  1  state!=IDLE or inflight!=0
issue_cnt  output  CNT_W  total issued ops, wraps

Behaviour:
- Reset (rst_n low, async):
  - req_ready, dp_inp1, dp_inp2, dp_en, rsp_valid, rsp_id, rsp_out, busy, issue_cnt all 0.
  - rr_ptr=0, state=IDLE, tag pipeline and inflight cleared.
  - Reset mid-operation drops all in-flight ops; no rsp for them after release.
- FSM states IDLE, RUN, DRAIN:
  - IDLE->RUN when enable & |req_valid.
  - RUN->DRAIN when enable=0 and inflight!=0.
  - RUN->IDLE when enable=0 or no valid, and inflight==0 (next-cycle value).
  - DRAIN->IDLE when inflight reaches 0; enable is ignored in DRAIN.
  - DRAIN->RUN is never taken directly.
- Grant (combinational):
  - Valid only when enable=1 and state!=DRAIN.
  - req_ready is one-hot on the first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ; otherwise all zero.
  - req_ready never asserts for a requester whose req_valid is low.
- Pointer: on transfer of requester g, rr_ptr <= (g+1) mod NUM_REQ; unchanged otherwise.
- Issue timing (handshake at cycle T):
  - Cycle T+1: dp_inp1/dp_inp2 = granted operands, dp_en=1.
  - Cycles with no issue: dp_en=0, dp_inp1=dp_inp2=0.
- Tag pipeline: LATENCY-deep shift of {valid, id} entered at T+1.
  - dp_out for the op is sampled at T+1+LATENCY-1 = T+LATENCY.
  - rsp_valid/rsp_id/rsp_out are registered from that sample and visible at cycle T+LATENCY+1.
  - Responses return in issue order.
- inflight: +1 on transfer, -1 when rsp_valid asserts; both in one cycle leaves it unchanged. Maximum LATENCY+1, so no overflow and no issue stall is required.
- issue_cnt increments on each transfer and wraps 2^CNT_W-1 -> 0.
- Back-to-back issue: one op per cycle sustained; results also return back-to-back.

Test Plan:
- LATENCY=3. Req 2 valid alone at cycle 10 with inp1=1, inp2=1 -> req_ready=0100 at 10; dp_en=1, dp_inp=1/1 at 11; rsp_valid=1, rsp_id=2, rsp_out=dp_out(cycle 13) at 14; issue_cnt=1.
- All four req_valid held from cycle 5, rr_ptr=0 -> grants 0,1,2,3,0 on cycles 5..9; rsp_id sequence 0,1,2,3,0 on cycles 9..13; inflight never exceeds 4.
- rr_ptr=2 (after granting 1), req_valid=1011 -> grant order 3,0,1,3; requester 2 is never granted.
- Issue at cycles 20 and 21, enable drops at 22 -> no grant at 22 despite valid; state DRAIN; rsps at 24 and 25; IDLE at 26; busy falls at 26.
- Issue at cycle 30, rst_n low at 32 for 1 cycle -> all outputs 0 immediately; no rsp at 34; issue_cnt=0.
- Preload by issuing 65535 ops, then one more issue -> issue_cnt reads 0xFFFF, then 0x0000; normal rsp is still produced.
